// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: FSM encoding, flag layout and default widths shared by the ALU arbiter and its ALU.
package alu_arb_pkg;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_OP_WIDTH = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int FLAG_EQ   = 2;
   localparam int FLAG_OVF  = 1;
   localparam int FLAG_ZERO = 0;

   function automatic logic [2:0] pack_flags(input logic equal, input logic overflow, input logic zero);
      logic [2:0] f;
      f            = 3'b000;
      f[FLAG_EQ]   = equal;
      f[FLAG_OVF]  = overflow;
      f[FLAG_ZERO] = zero;
      return f;
   endfunction

   function automatic logic [1:0] onehot2(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_arb_rr2.sv
// alu_arb_rr2: two-way grant; on a tie rr_ptr names the winner.
// With ALU_ARB_FIXED_PRIORITY_EN defined, requester 0 wins every tie and rr_ptr is ignored.
module alu_arb_rr2
   import alu_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       rr_ptr,
   output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIORITY_EN
   logic unused_rr_ptr;
   assign unused_rr_ptr = rr_ptr;
`endif

   // One-hot grant among the valid requesters
   always_comb begin
      grant = 2'b00;
      if (valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
         grant = onehot2(1'b0);
`else
         grant = onehot2(rr_ptr);
`endif
      end else begin
         grant = valid;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// Define ALU_ARB_FIXED_PRIORITY_EN to make requester 0 win every tie.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int OP_WIDTH    = DEF_OP_WIDTH,
   parameter int ALU_LATENCY = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                r0_valid,
   output logic                r0_ready,
   input  logic [WIDTH-1:0]    r0_x,
   input  logic [WIDTH-1:0]    r0_y,
   input  logic [OP_WIDTH-1:0] r0_op,
   input  logic                r1_valid,
   output logic                r1_ready,
   input  logic [WIDTH-1:0]    r1_x,
   input  logic [WIDTH-1:0]    r1_y,
   input  logic [OP_WIDTH-1:0] r1_op,
   output logic [1:0]          resp_valid,
   input  logic [1:0]          resp_ready,
   output logic [WIDTH-1:0]    resp_z,
   output logic [2:0]          resp_flags,
   output logic [WIDTH-1:0]    alu_x,
   output logic [WIDTH-1:0]    alu_y,
   output logic [OP_WIDTH-1:0] alu_op,
   input  logic [WIDTH-1:0]    alu_z,
   input  logic                alu_equal,
   input  logic                alu_overflow,
   input  logic                alu_zero,
   output logic                busy
);

   generate
      if (ALU_LATENCY < 1 || ALU_LATENCY > 15) begin : g_bad_latency
         $error("alu_arbiter: ALU_LATENCY must be within 1..15");
      end
   endgenerate

   localparam logic [3:0] CNT_LOAD = 4'(ALU_LATENCY - 1);

   logic [1:0] state_r;
   logic [3:0] cnt_r;
   logic       owner_r;
   logic       rr_ptr_r;
   logic [1:0] grant_s;
   logic       xfer_s;

   alu_arb_rr2 u_rr2 (
      .valid  ({r1_valid, r0_valid}),
      .rr_ptr (rr_ptr_r),
      .grant  (grant_s)
   );

   // Readies only in IDLE, response valid only in RESP
   always_comb begin
      xfer_s     = 1'b0;
      r0_ready   = 1'b0;
      r1_ready   = 1'b0;
      resp_valid = 2'b00;
      if (state_r == ST_IDLE) begin
         xfer_s   = |grant_s;
         r0_ready = grant_s[0];
         r1_ready = grant_s[1];
      end else if (state_r == ST_RESP) begin
         resp_valid = onehot2(owner_r);
      end else begin
         xfer_s = 1'b0;
      end
   end

   assign busy = (state_r != ST_IDLE);

   // Grant, operand launch, latency count and result capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 4'd0;
         owner_r    <= 1'b0;
         rr_ptr_r   <= 1'b0;
         alu_x      <= '0;
         alu_y      <= '0;
         alu_op     <= '0;
         resp_z     <= '0;
         resp_flags <= 3'b000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (xfer_s) begin
                  alu_x   <= grant_s[1] ? r1_x  : r0_x;
                  alu_y   <= grant_s[1] ? r1_y  : r0_y;
                  alu_op  <= grant_s[1] ? r1_op : r0_op;
                  owner_r <= grant_s[1];
                  cnt_r   <= CNT_LOAD;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
                  rr_ptr_r <= ~grant_s[1];
`endif
                  state_r <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (cnt_r == 4'd0) begin
                  resp_z     <= alu_z;
                  resp_flags <= pack_flags(alu_equal, alu_overflow, alu_zero);
                  state_r    <= ST_RESP;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            ST_RESP: begin
               // Only the owner's ready retires the response
               if (resp_ready[owner_r]) begin
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;

   localparam int W     = 32;
   localparam int OW    = 4;
   localparam int LAT_A = 1;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          r0_valid = 1'b0, r1_valid = 1'b0, r0_ready, r1_ready;
   logic [W-1:0]  r0_x = '0, r0_y = '0, r1_x = '0, r1_y = '0;
   logic [OW-1:0] r0_op = '0, r1_op = '0;
   logic [1:0]    resp_valid, resp_ready = 2'b00;
   logic [W-1:0]  resp_z, alu_x, alu_y, alu_z;
   logic [2:0]    resp_flags;
   logic [OW-1:0] alu_op;
   logic          alu_equal, alu_overflow, alu_zero, busy;

   logic          b_r0_valid = 1'b0, b_r1_valid = 1'b0, b_r0_ready, b_r1_ready;
   logic [1:0]    b_resp_valid, b_resp_ready = 2'b11;
   logic [W-1:0]  b_resp_z, b_alu_x, b_alu_y, b_alu_z;
   logic [2:0]    b_resp_flags;
   logic [OW-1:0] b_alu_op;
   logic          b_alu_equal, b_alu_overflow, b_alu_zero, b_busy;

   int checks = 0;
   int errors = 0;

   // Reference ALU: returns {z, equal, overflow, zero}
   function automatic logic [W+2:0] alu_f(input logic [W-1:0] x, input logic [W-1:0] y, input logic [OW-1:0] op);
      logic [W-1:0] z;
      logic         ovf;
      ovf = 1'b0;
      case (op)
         4'h0: z = x & y;
         4'h1: z = x | y;
         4'h2: begin z = x + y; ovf = (x[W-1] == y[W-1]) && (z[W-1] != x[W-1]); end
         4'h3: begin z = x - y; ovf = (x[W-1] != y[W-1]) && (z[W-1] != x[W-1]); end
         4'h4: z = x ^ y;
         default: z = x;
      endcase
      return {z, (x == y), ovf, (z == '0)};
   endfunction

   assign {alu_z, alu_equal, alu_overflow, alu_zero}         = alu_f(alu_x, alu_y, alu_op);
   assign {b_alu_z, b_alu_equal, b_alu_overflow, b_alu_zero} = alu_f(b_alu_x, b_alu_y, b_alu_op);

   alu_arbiter #(.WIDTH(W), .OP_WIDTH(OW), .ALU_LATENCY(LAT_A)) u_dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_x(r0_x), .r0_y(r0_y), .r0_op(r0_op),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_x(r1_x), .r1_y(r1_y), .r1_op(r1_op),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_z(resp_z), .resp_flags(resp_flags),
      .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_z(alu_z),
      .alu_equal(alu_equal), .alu_overflow(alu_overflow), .alu_zero(alu_zero), .busy(busy)
   );

   alu_arbiter #(.WIDTH(W), .OP_WIDTH(OW), .ALU_LATENCY(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .r0_valid(b_r0_valid), .r0_ready(b_r0_ready), .r0_x(r0_x), .r0_y(r0_y), .r0_op(r0_op),
      .r1_valid(b_r1_valid), .r1_ready(b_r1_ready), .r1_x(r1_x), .r1_y(r1_y), .r1_op(r1_op),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_z(b_resp_z), .resp_flags(b_resp_flags),
      .alu_x(b_alu_x), .alu_y(b_alu_y), .alu_op(b_alu_op), .alu_z(b_alu_z),
      .alu_equal(b_alu_equal), .alu_overflow(b_alu_overflow), .alu_zero(b_alu_zero), .busy(b_busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model of u_dut: owner (-1 = free), cycles since accept, tie pointer
   int            m_owner = -1;
   int            m_age   = 0;
   logic          m_ptr   = 1'b0;
   logic [W-1:0]  m_x = '0, m_y = '0, m_z = '0;
   logic [OW-1:0] m_op = '0;
   logic [2:0]    m_fl = 3'b000;
   logic [W+2:0]  m_res;
   logic [1:0]    m_eg, m_erv;
   bit            m_done;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_resp_valid", resp_valid, 2'b00);
         chk("rst_busy", busy, 1'b0);
         chk("rst_alu_x", alu_x, '0);
         chk("rst_resp_z", resp_z, '0);
         chk("rst_ready", {r1_ready, r0_ready}, 2'b00);
         m_owner = -1; m_age = 0; m_ptr = 1'b0;
         m_x = '0; m_y = '0; m_op = '0; m_z = '0; m_fl = 3'b000;
      end else begin
         m_eg = 2'b00;
         if (m_owner < 0) begin
            if (r0_valid && r1_valid) m_eg = (FIXED || !m_ptr) ? 2'b01 : 2'b10;
            else m_eg = {r1_valid, r0_valid};
         end
         m_erv = (m_owner >= 0 && m_age > LAT_A) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
         chk("m_ready", {r1_ready, r0_ready}, m_eg);
         chk("m_busy", busy, (m_owner >= 0));
         chk("m_resp_valid", resp_valid, m_erv);
         chk("m_resp_z", resp_z, m_z);
         chk("m_resp_flags", resp_flags, m_fl);
         chk("m_alu_in", {alu_x, alu_y, alu_op}, {m_x, m_y, m_op});
         if (m_owner < 0) begin
            if (m_eg != 2'b00) begin
               m_owner = m_eg[1] ? 1 : 0;
               m_x  = m_eg[1] ? r1_x  : r0_x;
               m_y  = m_eg[1] ? r1_y  : r0_y;
               m_op = m_eg[1] ? r1_op : r0_op;
               m_age = 1;
               if (!FIXED) m_ptr = ~m_eg[1];
            end
         end else begin
            m_done = (m_erv != 2'b00) && resp_ready[m_owner];
            m_age++;
            if (m_age == LAT_A + 1) begin
               m_res = alu_f(m_x, m_y, m_op);
               m_z   = m_res[W+2:3];
               m_fl  = m_res[2:0];
            end
            if (m_done) m_owner = -1;
         end
      end
   end

   task automatic do_op(input bit req, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [OW-1:0] op, output logic [W-1:0] z, output logic [2:0] fl);
      int n;
      if (req) begin r1_x = x; r1_y = y; r1_op = op; r1_valid = 1'b1; end
      else     begin r0_x = x; r0_y = y; r0_op = op; r0_valid = 1'b1; end
      n = 0;
      #1;
      while (!(req ? r1_ready : r0_ready) && n < 40) begin @(posedge clk); #1; n++; end
      if (n >= 40) chk("grant_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      if (req) r1_valid = 1'b0; else r0_valid = 1'b0;
      n = 0;
      while (!resp_valid[req] && n < 40) begin @(posedge clk); #1; n++; end
      if (n >= 40) chk("resp_timeout", 1'b0, 1'b1);
      z  = resp_z;
      fl = resp_flags;
      @(posedge clk); #1;
   endtask

   function automatic logic [W-1:0] rnd_val();
      case ($urandom_range(0, 3))
         0: return 32'h7FFF_FFFF;
         1: return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   logic [W-1:0] z;
   logic [2:0]   fl;
   int           n, g;
   bit           hs0, hs1;

   initial begin
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      chk("reset_busy", busy, 1'b0);
      chk("reset_alu_op", alu_op, 4'h0);

      // r0 alone: 5 + 7
      resp_ready = 2'b11;
      r0_x = 32'd5; r0_y = 32'd7; r0_op = 4'h2; r0_valid = 1'b1;
      #1 chk("t1_r0_ready_c0", r0_ready, 1'b1);
      @(posedge clk); #1; r0_valid = 1'b0;
      chk("t1_c1_resp_valid", resp_valid, 2'b00);
      @(posedge clk); #1;
      chk("t1_c2_resp_valid", resp_valid, 2'b01);
      chk("t1_resp_z", resp_z, 32'd12);
      chk("t1_resp_flags", resp_flags, 3'b000);
      @(posedge clk); #1;
      chk("t1_c3_resp_valid", resp_valid, 2'b00);

      // continuous contention from a fresh reset
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      r0_x = 32'd1; r0_y = 32'd2; r0_op = 4'h2;
      r1_x = 32'd10; r1_y = 32'd3; r1_op = 4'h3;
      r0_valid = 1'b1; r1_valid = 1'b1;
      g = 0; n = 0;
      while (g < 4 && n < 60) begin
         #1;
         chk("rr_one_ready", r0_ready & r1_ready, 1'b0);
         if (r0_ready || r1_ready) begin
            chk("rr_grant_id", r1_ready, FIXED ? 1'b0 : g[0]);
            g++;
         end
         if (g < 4) begin @(posedge clk); #1; n++; end
      end
      if (g < 4) chk("rr_timeout", g, 4);
      @(posedge clk); #1;
      r0_valid = 1'b0; r1_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // overflow and equal/zero flags
      do_op(1'b0, 32'h7FFF_FFFF, 32'd1, 4'h2, z, fl);
      chk("ovf_z", z, 32'h8000_0000);
      chk("ovf_flags", fl, 3'b010);
      do_op(1'b1, 32'd9, 32'd9, 4'h3, z, fl);
      chk("sub_z", z, 32'd0);
      chk("sub_flags", fl, 3'b101);

      // response stall: 6 ^ 3 held while r1 waits
      resp_ready = 2'b00;
      r0_x = 32'd6; r0_y = 32'd3; r0_op = 4'h4; r0_valid = 1'b1;
      #1 chk("stall_r0_ready", r0_ready, 1'b1);
      @(posedge clk); #1; r0_valid = 1'b0;
      n = 0;
      while (resp_valid != 2'b01 && n < 40) begin @(posedge clk); #1; n++; end
      if (n >= 40) chk("stall_timeout", 1'b0, 1'b1);
      r1_x = 32'd4; r1_y = 32'd4; r1_op = 4'h0; r1_valid = 1'b1;
      resp_ready = 2'b10;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_resp_valid", resp_valid, 2'b01);
         chk("stall_resp_z", resp_z, 32'd5);
         chk("stall_resp_flags", resp_flags, 3'b000);
         chk("stall_r1_ready", r1_ready, 1'b0);
         @(posedge clk); #1;
      end
      resp_ready = 2'b11;
      n = 0;
      while (!r1_ready && n < 40) begin @(posedge clk); #1; n++; end
      if (n >= 40) chk("stall_r1_timeout", 1'b0, 1'b1);
      @(posedge clk); #1; r1_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // reset in the middle of a latency-4 operation
      r0_x = 32'h1234; r0_y = 32'd1; r0_op = 4'h2; b_r0_valid = 1'b1;
      #1 chk("b_r0_ready", b_r0_ready, 1'b1);
      @(posedge clk); #1; b_r0_valid = 1'b0;
      @(posedge clk); #1;
      chk("b_busy_exec", b_busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("b_rst_busy", b_busy, 1'b0);
      chk("b_rst_resp_valid", b_resp_valid, 2'b00);
      chk("b_rst_alu_x", b_alu_x, '0);
      @(posedge clk); #1; rst = 1'b0;
      r1_x = 32'd3; r1_y = 32'd4; r1_op = 4'h2;
      b_r0_valid = 1'b1; b_r1_valid = 1'b1;
      #1;
      chk("b_tie_r0_ready", b_r0_ready, 1'b1);
      chk("b_tie_r1_ready", b_r1_ready, 1'b0);
      @(posedge clk); #1; b_r0_valid = 1'b0;
      n = 0;
      while (!b_r1_ready && n < 40) begin @(posedge clk); #1; n++; end
      if (n >= 40) chk("b_r1_timeout", 1'b0, 1'b1);
      @(posedge clk); #1; b_r1_valid = 1'b0;
      n = 1;
      while (b_resp_valid != 2'b10 && n < 30) begin @(posedge clk); #1; n++; end
      chk("b_latency", n, 5);
      chk("b_resp_z", b_resp_z, 32'd7);
      chk("b_resp_flags", b_resp_flags, 3'b000);
      repeat (3) @(posedge clk);
      #1;

      // randomized traffic on the latency-1 instance
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         hs0 = r0_valid & r0_ready;
         hs1 = r1_valid & r1_ready;
         @(posedge clk); #1;
         if (hs0 || !r0_valid) begin
            r0_valid = ($urandom_range(0, 2) != 0);
            r0_x  = rnd_val();
            r0_y  = ($urandom_range(0, 3) == 0) ? r0_x : rnd_val();
            r0_op = OW'($urandom_range(0, 5));
         end
         if (hs1 || !r1_valid) begin
            r1_valid = ($urandom_range(0, 2) != 0);
            r1_x  = rnd_val();
            r1_y  = ($urandom_range(0, 3) == 0) ? r1_x : rnd_val();
            r1_op = OW'($urandom_range(0, 5));
         end
         resp_ready = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      @(posedge clk); #1;
      r0_valid = 1'b0; r1_valid = 1'b0; resp_ready = 2'b11;
      repeat (10) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
